// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and FSM state type for the memory stage
package mem_pkg;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response bus between mem_stage and memory
interface mem_stage_if;

    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_ready;
    logic [31:0] mem_read_data;

    modport master (
        output mem_request, mem_write, mem_address, mem_write_data,
        input  mem_ready, mem_read_data
    );

    modport slave (
        input  mem_request, mem_write, mem_address, mem_write_data,
        output mem_ready, mem_read_data
    );

endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with wait-state stall, timeout abort and write-back register
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ex_mem_alu_result,
    input  logic        ex_mem_alu_zero,
    input  logic        ex_mem_write_register,
    input  logic [4:0]  ex_mem_register_number,
    input  logic [1:0]  ex_mem_register_source,
    input  logic        ex_mem_write_data,
    input  logic [31:0] ex_mem_data,
    input  logic [31:0] ex_mem_pc4,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    output logic        stall,
    output logic        mem_wb_write_register,
    output logic [4:0]  mem_wb_register_number,
    output logic [31:0] mem_wb_register_data,
    output logic        mem_wb_fault,
    output logic [15:0] stall_count
);

    state_t      state, state_next;
    logic [31:0] lat_addr, lat_data;
    logic        lat_store, lat_wr;
    logic [4:0]  lat_reg;
    logic [1:0]  lat_src;
    logic [15:0] wait_cnt;

    logic        in_store, in_access, in_aligned, timed_out;
    logic [31:0] sel_addr, sel_data;
    logic        sel_store, sel_wr;
    logic [4:0]  sel_reg;
    logic [1:0]  sel_src;
    logic        latch_en, fault_now;
    logic        wb_wr_next, wb_fault_next;
    logic [4:0]  wb_reg_next;
    logic [31:0] wb_data_next;
    logic        unused_alu_zero;

    assign unused_alu_zero = ex_mem_alu_zero;

    assign in_store   = ex_mem_write_data;
    assign in_access  = in_store || (ex_mem_register_source == SRC_MEM);
    assign in_aligned = (ex_mem_alu_result[1:0] == 2'b00);
    assign timed_out  = (wait_cnt == 16'(TIMEOUT));

    always_comb begin
        state_next = state;
        mem_request = 1'b0;
        stall = 1'b0;
        latch_en = 1'b0;
        fault_now = 1'b0;
        // While waiting, everything the memory and write-back see comes from the latched copy
        if (state == WAIT) begin
            sel_addr  = lat_addr;
            sel_data  = lat_data;
            sel_store = lat_store;
            sel_wr    = lat_wr;
            sel_reg   = lat_reg;
            sel_src   = lat_src;
        end else begin
            sel_addr  = ex_mem_alu_result;
            sel_data  = ex_mem_data;
            sel_store = in_store;
            sel_wr    = ex_mem_write_register;
            sel_reg   = ex_mem_register_number;
            sel_src   = ex_mem_register_source;
        end

        case (state)
            IDLE: begin
                if (in_access) begin
                    if (!in_aligned) begin
                        fault_now = 1'b1;
                    end else begin
                        mem_request = 1'b1;
                        if (!mem_ready) begin
                            stall = 1'b1;
                            latch_en = 1'b1;
                            state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (timed_out) begin
                    fault_now = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_request = 1'b1;
                    if (mem_ready) state_next = IDLE;
                    else stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        mem_address    = sel_addr;
        mem_write_data = sel_data;
        mem_write      = mem_request && sel_store;

        wb_wr_next    = sel_wr && !sel_store;
        wb_fault_next = 1'b0;
        wb_reg_next   = sel_reg;
        case (sel_src)
            SRC_MEM: wb_data_next = mem_read_data;
            SRC_PC4: wb_data_next = ex_mem_pc4;
            default: wb_data_next = sel_addr;
        endcase

        if (stall) begin
            wb_wr_next   = 1'b0;
            wb_reg_next  = 5'd0;
            wb_data_next = 32'd0;
        end else if (fault_now) begin
            wb_wr_next    = 1'b0;
            wb_fault_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            wait_cnt               <= 16'd0;
            stall_count            <= 16'd0;
            lat_addr               <= 32'd0;
            lat_data               <= 32'd0;
            lat_store              <= 1'b0;
            lat_wr                 <= 1'b0;
            lat_reg                <= 5'd0;
            lat_src                <= SRC_ALU;
            mem_wb_write_register  <= 1'b0;
            mem_wb_register_number <= 5'd0;
            mem_wb_register_data   <= 32'd0;
            mem_wb_fault           <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_en) begin
                lat_addr  <= ex_mem_alu_result;
                lat_data  <= ex_mem_data;
                lat_store <= in_store;
                lat_wr    <= ex_mem_write_register;
                lat_reg   <= ex_mem_register_number;
                lat_src   <= ex_mem_register_source;
            end
            // Only stalled WAIT cycles count toward the timeout
            if (state == WAIT && stall) wait_cnt <= wait_cnt + 16'd1;
            else wait_cnt <= 16'd0;
            if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            mem_wb_write_register  <= wb_wr_next;
            mem_wb_register_number <= wb_reg_next;
            mem_wb_register_data   <= wb_data_next;
            mem_wb_fault           <= wb_fault_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        write_register;
    logic [4:0]  register_number;
    logic [1:0]  register_source;
    logic        write_data;
    logic [31:0] data;
    logic [31:0] pc4;
    logic        stall;
    logic        wb_wr;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_fault;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(15)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .ex_mem_alu_result      (alu_result),
        .ex_mem_alu_zero        (alu_zero),
        .ex_mem_write_register  (write_register),
        .ex_mem_register_number (register_number),
        .ex_mem_register_source (register_source),
        .ex_mem_write_data      (write_data),
        .ex_mem_data            (data),
        .ex_mem_pc4             (pc4),
        .mem_request            (bus.mem_request),
        .mem_write              (bus.mem_write),
        .mem_address            (bus.mem_address),
        .mem_write_data         (bus.mem_write_data),
        .mem_ready              (bus.mem_ready),
        .mem_read_data          (bus.mem_read_data),
        .stall                  (stall),
        .mem_wb_write_register  (wb_wr),
        .mem_wb_register_number (wb_reg),
        .mem_wb_register_data   (wb_data),
        .mem_wb_fault           (wb_fault),
        .stall_count            (stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] src, input logic st,
                         input logic wr, input logic [4:0] rn, input logic [31:0] d);
        alu_result = a;
        register_source = src;
        write_data = st;
        write_register = wr;
        register_number = rn;
        data = d;
    endtask

    task automatic idle_inputs();
        drive(32'h0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0);
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        alu_zero = 1'b0;
        pc4 = 32'h0000_1004;
        bus.mem_read_data = 32'h0;
        idle_inputs();
        tick();
        tick();
        check("reset_wb_wr", 32'(wb_wr), 32'd0);
        check("reset_wb_fault", 32'(wb_fault), 32'd0);
        check("reset_stall_count", 32'(stall_count), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_request", 32'(bus.mem_request), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);

        // ALU op; mem_ready high must be ignored with no request
        drive(32'h1234, 2'b00, 1'b0, 1'b1, 5'd5, 32'h0);
        bus.mem_ready = 1'b1;
        #1;
        check("alu_request", 32'(bus.mem_request), 32'd0);
        tick();
        check("alu_wb_wr", 32'(wb_wr), 32'd1);
        check("alu_wb_reg", 32'(wb_reg), 32'd5);
        check("alu_wb_data", wb_data, 32'h1234);

        // Link value write-back
        drive(32'h0000_7777, 2'b10, 1'b0, 1'b1, 5'd31, 32'h0);
        pc4 = 32'h2000_0004;
        tick();
        check("pc4_wb_reg", 32'(wb_reg), 32'd31);
        check("pc4_wb_data", wb_data, 32'h2000_0004);

        // Zero-wait load
        drive(32'h100, 2'b01, 1'b0, 1'b1, 5'd7, 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_read_data = 32'hDEAD_BEEF;
        #1;
        check("ld0_request", 32'(bus.mem_request), 32'd1);
        check("ld0_address", bus.mem_address, 32'h100);
        check("ld0_write", 32'(bus.mem_write), 32'd0);
        check("ld0_stall", 32'(stall), 32'd0);
        tick();
        check("ld0_wb_wr", 32'(wb_wr), 32'd1);
        check("ld0_wb_reg", 32'(wb_reg), 32'd7);
        check("ld0_wb_data", wb_data, 32'hDEAD_BEEF);
        check("ld0_stall_count", 32'(stall_count), 32'd0);

        // Store with 3 wait cycles; inputs change after the first cycle
        drive(32'h40, 2'b00, 1'b1, 1'b1, 5'd3, 32'h55);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            #1;
            check("st_request", 32'(bus.mem_request), 32'd1);
            check("st_address", bus.mem_address, 32'h40);
            check("st_write", 32'(bus.mem_write), 32'd1);
            check("st_wdata", bus.mem_write_data, 32'h55);
            check("st_stall", 32'(stall), (i < 3) ? 32'd1 : 32'd0);
            tick();
            check("st_wb_wr", 32'(wb_wr), 32'd0);
            check("st_wb_fault", 32'(wb_fault), 32'd0);
            if (i == 0) drive(32'h999, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0);
        end
        check("st_stall_count", 32'(stall_count), 32'd3);

        // Misaligned load
        drive(32'h102, 2'b01, 1'b0, 1'b1, 5'd9, 32'h0);
        bus.mem_ready = 1'b1;
        #1;
        check("mis_request", 32'(bus.mem_request), 32'd0);
        check("mis_stall", 32'(stall), 32'd0);
        tick();
        check("mis_wb_fault", 32'(wb_fault), 32'd1);
        check("mis_wb_wr", 32'(wb_wr), 32'd0);
        idle_inputs();
        tick();
        check("mis_fault_clear", 32'(wb_fault), 32'd0);

        // Timeout: one IDLE stall cycle, 15 stalled WAIT cycles, then abort
        drive(32'h200, 2'b01, 1'b0, 1'b1, 5'd4, 32'h0);
        bus.mem_ready = 1'b0;
        #1;
        check("to_first_stall", 32'(stall), 32'd1);
        tick();
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            #1;
            check("to_wait_stall", 32'(stall), 32'd1);
            tick();
        end
        #1;
        check("to_abort_request", 32'(bus.mem_request), 32'd0);
        check("to_abort_stall", 32'(stall), 32'd0);
        tick();
        check("to_wb_fault", 32'(wb_fault), 32'd1);
        check("to_wb_wr", 32'(wb_wr), 32'd0);
        check("to_stall_count", 32'(stall_count), 32'd19);
        check("to_idle_request", 32'(bus.mem_request), 32'd0);
        tick();
        check("to_fault_one_cycle", 32'(wb_fault), 32'd0);

        // Reset asserted mid-WAIT
        drive(32'h80, 2'b00, 1'b1, 1'b0, 5'd0, 32'hAA);
        bus.mem_ready = 1'b0;
        tick();
        tick();
        #1;
        check("rst_wait_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_request", 32'(bus.mem_request), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_stall_count", 32'(stall_count), 32'd0);
        tick();
        check("rst_after_request", 32'(bus.mem_request), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
